// File: rtl/trace_tx.sv
// Retirement trace transmitter: captures one record per retired instruction into a
// FIFO and serializes it as a 32-bit word stream. Optional macro: TRACE_TX_MEM_WORDS_EN.
module trace_tx #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ret_valid,
    input  logic                       mem_wait,
    input  logic [31:0]                ret_pc,
    input  logic [31:0]                ret_inst,
    input  logic                       ret_flush,
    input  logic                       ret_jump,
    input  logic [31:0]                ret_jump_addr,
    input  logic                       ret_rd_we,
    input  logic [4:0]                 ret_rd,
    input  logic [31:0]                ret_rd_data,
    input  logic                       ret_mem_rd,
    input  logic                       ret_mem_wr,
    input  logic [31:0]                ret_mem_addr,
    input  logic [31:0]                ret_mem_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [31:0]                tx_data,
    output logic                       tx_last,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [15:0]                drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_LVL  = (AW + 1)'(1);

    typedef struct packed {
        logic [31:0] hdr;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] jump_addr;
        logic [31:0] rd_data;
`ifdef TRACE_TX_MEM_WORDS_EN
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
`endif
    } rec_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PC,
        S_INST,
        S_JMP,
        S_RD
`ifdef TRACE_TX_MEM_WORDS_EN
        ,
        S_MADDR,
        S_MDATA
`endif
    } state_t;

    rec_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [15:0]   seq;
    logic          ovf_pend;
    state_t        state, state_nxt, follow;

    logic   capture, full, store, drop, hs, last, pop, more;
    logic   has_jmp, has_rd, has_mem, is_flush;
    logic [31:0] cap_hdr;
    rec_t   cap_rec, head;

`ifndef TRACE_TX_MEM_WORDS_EN
    logic unused_mem;
    assign unused_mem = ^{ret_mem_addr, ret_mem_data};
`endif

    assign capture = ret_valid & ~mem_wait;
    assign full    = (count == FULL_LVL);
    assign store   = capture & ~full;
    assign drop    = capture & full;

    // A flushed slot keeps only seq and the overflow marker; all retire flags are zeroed.
    always_comb begin
        if (ret_flush)
            cap_hdr = {seq, ovf_pend, 1'b1, 14'b0};
        else
            cap_hdr = {seq, ovf_pend, 1'b0, ret_jump, ret_rd_we, ret_rd,
                       ret_mem_rd, ret_mem_wr, 5'b0};
    end

    always_comb begin
        cap_rec           = '0;
        cap_rec.hdr       = cap_hdr;
        cap_rec.pc        = ret_pc;
        cap_rec.inst      = ret_inst;
        cap_rec.jump_addr = ret_jump_addr;
        cap_rec.rd_data   = ret_rd_data;
`ifdef TRACE_TX_MEM_WORDS_EN
        cap_rec.mem_addr  = ret_mem_addr;
        cap_rec.mem_data  = ret_mem_data;
`endif
    end

    // NOTE: the record storage is deliberately not reset; validity is tracked by
    // the reset pointers and count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (store)
            mem[wr_ptr] <= cap_rec;
    end

    assign head = mem[rd_ptr];

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            seq        <= '0;
            ovf_pend   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (capture)
                seq <= seq + 16'd1;
            if (store)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (store && !pop)
                count <= count + ONE_LVL;
            else if (pop && !store)
                count <= count - ONE_LVL;
            if (drop) begin
                ovf_pend <= 1'b1;
                if (drop_count != 16'hFFFF)
                    drop_count <= drop_count + 16'd1;
            end else if (store) begin
                ovf_pend <= 1'b0;
            end
        end
    end

    assign fifo_level = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    assign is_flush = head.hdr[14];
    assign has_jmp  = head.hdr[13];
    assign has_rd   = head.hdr[12] & (|head.hdr[11:7]);
`ifdef TRACE_TX_MEM_WORDS_EN
    assign has_mem  = head.hdr[6] | head.hdr[5];
`else
    assign has_mem  = 1'b0;
`endif

    // follow is the word after the current one; S_IDLE there means end of record.
    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        follow    = S_IDLE;
        state_nxt = state;
        tx_data   = '0;
        unique case (state)
            S_HDR: begin
                tx_data = head.hdr;
                follow  = S_PC;
            end
            S_PC: begin
                tx_data = head.pc;
                follow  = is_flush ? S_IDLE : S_INST;
            end
            S_INST: begin
                tx_data = head.inst;
                if (has_jmp)      follow = S_JMP;
                else if (has_rd)  follow = S_RD;
`ifdef TRACE_TX_MEM_WORDS_EN
                else if (has_mem) follow = S_MADDR;
`endif
            end
            S_JMP: begin
                tx_data = head.jump_addr;
                if (has_rd)       follow = S_RD;
`ifdef TRACE_TX_MEM_WORDS_EN
                else if (has_mem) follow = S_MADDR;
`endif
            end
            S_RD: begin
                tx_data = head.rd_data;
`ifdef TRACE_TX_MEM_WORDS_EN
                if (has_mem)      follow = S_MADDR;
`endif
            end
`ifdef TRACE_TX_MEM_WORDS_EN
            S_MADDR: begin
                tx_data = head.mem_addr;
                follow  = S_MDATA;
            end
            S_MDATA: begin
                tx_data = head.mem_data;
            end
`endif
            default: begin
                tx_data = '0;
            end
        endcase

        // IDLE implies an empty FIFO, so a store here starts the next header directly.
        if (state == S_IDLE) begin
            if (store)
                state_nxt = S_HDR;
        end else if (hs) begin
            if (last)
                state_nxt = more ? S_HDR : S_IDLE;
            else
                state_nxt = follow;
        end
    end

    assign tx_valid = (state != S_IDLE);
    assign last     = tx_valid && (follow == S_IDLE);
    assign tx_last  = last;
    assign hs       = tx_valid & tx_ready;
    assign pop      = hs & last;
    assign more     = (count > ONE_LVL) | store;

    logic unused_has_mem;
    assign unused_has_mem = has_mem;

endmodule

// File: tb/tb_trace_tx.sv
// Scoreboard bench for trace_tx: directed retire events push expected words; a
// negedge monitor pops and compares on every handshake.
module tb_trace_tx;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ret_valid, mem_wait, ret_flush, ret_jump, ret_rd_we;
    logic        ret_mem_rd, ret_mem_wr;
    logic [31:0] ret_pc, ret_inst, ret_jump_addr, ret_rd_data;
    logic [31:0] ret_mem_addr, ret_mem_data;
    logic [4:0]  ret_rd;
    logic        tx_valid, tx_ready, tx_last;
    logic [31:0] tx_data;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [15:0] drop_count;

    trace_tx #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .ret_valid(ret_valid), .mem_wait(mem_wait),
        .ret_pc(ret_pc), .ret_inst(ret_inst),
        .ret_flush(ret_flush), .ret_jump(ret_jump), .ret_jump_addr(ret_jump_addr),
        .ret_rd_we(ret_rd_we), .ret_rd(ret_rd), .ret_rd_data(ret_rd_data),
        .ret_mem_rd(ret_mem_rd), .ret_mem_wr(ret_mem_wr),
        .ret_mem_addr(ret_mem_addr), .ret_mem_data(ret_mem_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_last(tx_last), .fifo_level(fifo_level), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare each handshaken word and verify hold-stability under backpressure.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {31'b0, tx_valid}, 32'd1);
                check("stall_data", tx_data, prev_data);
                check("stall_last", {31'b0, tx_last}, {31'b0, prev_last});
            end
            if (tx_valid && tx_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_word", tx_data, 32'hxxxx_xxxx);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("word", tx_data, e.data);
                    check("last", {31'b0, tx_last}, {31'b0, e.last});
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_last  = tx_last;
        end
    end

    task automatic push(input logic [31:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        q.push_back(e);
    endtask

    // Called at posedge+1; drives one retire for exactly one clock edge.
    task automatic issue(input logic [31:0] pc, input logic [31:0] inst,
                         input logic flush, input logic jump, input logic [31:0] jaddr,
                         input logic rd_we, input logic [4:0] rd, input logic [31:0] rdd,
                         input logic mrd, input logic mwr,
                         input logic [31:0] maddr, input logic [31:0] mdata,
                         input logic [31:0] exp_hdr, input bit stored);
        logic has_j, has_r, has_m;
        ret_valid = 1'b1; ret_pc = pc; ret_inst = inst; ret_flush = flush;
        ret_jump = jump; ret_jump_addr = jaddr; ret_rd_we = rd_we; ret_rd = rd;
        ret_rd_data = rdd; ret_mem_rd = mrd; ret_mem_wr = mwr;
        ret_mem_addr = maddr; ret_mem_data = mdata;
        if (stored) begin
            has_j = !flush && jump;
            has_r = !flush && rd_we && (rd != 5'd0);
`ifdef TRACE_TX_MEM_WORDS_EN
            has_m = !flush && (mrd || mwr);
`else
            has_m = 1'b0;
`endif
            push(exp_hdr, 1'b0);
            push(pc, flush);
            if (!flush) begin
                push(inst, !(has_j || has_r || has_m));
                if (has_j) push(jaddr, !(has_r || has_m));
                if (has_r) push(rdd, !has_m);
                if (has_m) begin
                    push(maddr, 1'b0);
                    push(mdata, 1'b1);
                end
            end
        end
        @(posedge clk); #1;
        ret_valid = 1'b0;
    endtask

    task automatic drain(input bit bp);
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            tx_ready = !(bp && (n % 3 == 1));
            @(posedge clk); #1;
            n++;
        end
        tx_ready = 1'b1;
        if (q.size() != 0)
            check("drain_timeout", q.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; ret_valid = 1'b0; mem_wait = 1'b0; tx_ready = 1'b1;
        ret_pc = '0; ret_inst = '0; ret_flush = 1'b0; ret_jump = 1'b0;
        ret_jump_addr = '0; ret_rd_we = 1'b0; ret_rd = '0; ret_rd_data = '0;
        ret_mem_rd = 1'b0; ret_mem_wr = 1'b0; ret_mem_addr = '0; ret_mem_data = '0;
        #1;
        check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("rst_tx_last", {31'b0, tx_last}, 32'd0);
        check("rst_tx_data", tx_data, 32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        do_reset();

        // seq 0: addi x1 -> header, pc, inst, rd_data
        issue(32'h100, 32'h0050_0093, 0, 0, 0, 1, 5'd1, 32'd5, 0, 0, 0, 0, 32'h0000_1080, 1);
        drain(0);
        // seq 1: flushed slot with stray flags set; only header + pc
        issue(32'h200, 32'hDEAD_BEEF, 1, 1, 32'h999, 1, 5'd3, 32'h77, 1, 0, 32'h44, 32'h55,
              32'h0001_4000, 1);
        drain(0);
        // seq 2: jump with rd_we to x0 -> no rd word
        issue(32'h300, 32'h0000_006F, 0, 1, 32'h340, 1, 5'd0, 32'h123, 0, 0, 0, 0,
              32'h0002_3000, 1);
        drain(0);
        // seq 3: store to 0x80 of 0xDEAD
        issue(32'h310, 32'h0020_2023, 0, 0, 0, 0, 5'd0, 0, 0, 1, 32'h80, 32'hDEAD,
              32'h0003_0020, 1);
        drain(0);

        // mem_wait blocks capture for 3 cycles; seq must stay at 4
        ret_valid = 1'b1; mem_wait = 1'b1;
        repeat (3) @(posedge clk);
        #1 ret_valid = 1'b0; mem_wait = 1'b0;
        check("memwait_level", 32'(fifo_level), 32'd0);
        check("memwait_valid", {31'b0, tx_valid}, 32'd0);
        issue(32'h400, 32'h0000_0013, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 32'h0004_0000, 1);
        drain(0);

        // seq 5..7 back to back, then drained with backpressure
        issue(32'h500, 32'h11, 0, 0, 0, 1, 5'd2, 32'hA5, 0, 0, 0, 0, 32'h0005_1100, 1);
        issue(32'h504, 32'h22, 1, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 32'h0006_4000, 1);
        issue(32'h508, 32'h33, 0, 1, 32'h600, 1, 5'd4, 32'h5A, 1, 0, 32'h90, 32'h1234,
              32'h0007_3240, 1);
        drain(1);

        // Overflow: DEPTH=8, sink stalled, 10 events -> 2 drops
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++)
            issue(32'h1000 + 32'(i * 4), 32'h13, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0,
                  {16'(i), 16'h0}, i < DEPTH);
        check("ovf_level", 32'(fifo_level), 32'd8);
        check("ovf_drops", 32'(drop_count), 32'd2);
        drain(0);
        issue(32'h2000, 32'h13, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 32'h000A_8000, 1);
        drain(0);
        check("ovf_drops_hold", 32'(drop_count), 32'd2);

        // Reset mid-record: outputs clear asynchronously, seq restarts at 0
        tx_ready = 1'b0;
        issue(32'h3000, 32'h13, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 32'h000B_0000, 0);
        check("midrec_valid", {31'b0, tx_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("async_tx_data", tx_data, 32'd0);
        check("async_level", 32'(fifo_level), 32'd0);
        check("async_drops", 32'(drop_count), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        issue(32'h4000, 32'h0000_0073, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 32'h0000_0000, 1);
        drain(0);
        check("final_idle", {31'b0, tx_valid}, 32'd0);
        check("final_queue", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_tx.md
TRACE_TX -- requirements
Module: trace_tx

Interface
- REQ-001: Parameter DEPTH, default 8, meaning record FIFO depth (power of two, 2..64).
- REQ-002: clk  input  1  rising-edge clock for all state.
- REQ-003: rst_n  input  1  reset; asynchronous, active-low (one clock, asynchronous active-low reset).
- REQ-004: ret_valid  input  1  an instruction retires this cycle.
- REQ-005: mem_wait  input  1  pipeline stalled; no capture while high.
- REQ-006: ret_pc  input  32  retiring PC.
- REQ-007: ret_inst  input  32  retiring instruction word.
- REQ-008: ret_flush  input  1  retiring slot was flushed.
- REQ-009: ret_jump  input  1  retiring instruction redirected PC.
- REQ-010: ret_jump_addr  input  32  redirect target.
- REQ-011: ret_rd_we  input  1  register write.
- REQ-012: ret_rd  input  5  destination register.
- REQ-013: ret_rd_data  input  32  register write data.
- REQ-014: ret_mem_rd  input  1  load performed.
- REQ-015: ret_mem_wr  input  1  store performed.
- REQ-016: ret_mem_addr  input  32  memory address.
- REQ-017: ret_mem_data  input  32  load or store data.
- REQ-018: tx_valid  output  1  tx_data holds a valid word.
- REQ-019: tx_ready  input  1  sink accepts the word.
- REQ-020: tx_data  output  32  stream word.
- REQ-021: tx_last  output  1  final word of a record.
- REQ-022: fifo_level  output  log2(DEPTH)+1  records held.
- REQ-023: drop_count  output  16  dropped records, saturating at 0xFFFF.

Function
- REQ-024: Capture event = ret_valid & !mem_wait; one record per event, sampled at the clock edge.
- REQ-025: 16-bit seq increments on every capture event, dropped or not; wraps 0xFFFF->0x0000.
- REQ-026: Event with FIFO full (pre-pop state of same cycle) is dropped; drop_count increments; pending-overflow flag set.
- REQ-027: Next stored record carries overflow=1; flag clears on that store.
- REQ-028: Header word: [31:16] seq, [15] overflow, [14] flush, [13] jump, [12] rd_we, [11:7] rd, [6] mem_rd, [5] mem_wr, [4:0] 0.
- REQ-029: Word order: header, pc, inst, jump_addr if jump, rd_data if rd_we & rd!=0, mem_addr then mem_data if (mem_rd|mem_wr) and the memory-word feature is compiled in.
- REQ-030: Flushed record emits header and pc only; every other flag and data field is forced to 0 in the header.
- REQ-031: Serializer FSM states: IDLE, HDR, PC, INST, JMP, RD, MADDR, MDATA. Optional states are skipped when not applicable. The state advances only on tx_valid & tx_ready.
- REQ-032: tx_last=1 on the final word of each record; the FIFO pops on the handshake of that word.
- REQ-033: An empty FIFO drives tx_valid low; the first header is presented the cycle after a store.
- REQ-034: No added bubbles between words or records while tx_ready stays high and the FIFO is non-empty.
- REQ-035: tx_data and tx_last are held stable while tx_valid & !tx_ready; tx_valid never drops before the handshake.
- REQ-036: Simultaneous store and pop leaves fifo_level unchanged.

Reset
- REQ-037: rst_n low drives the following immediately, without waiting for a clock edge: tx_valid=0, tx_last=0, tx_data=0, fifo_level=0, drop_count=0, seq=0, overflow flag=0, FSM=IDLE.
- REQ-038: Reset mid-record abandons that record; no partial record resumes after reset.

Configuration
- REQ-039: Macro TRACE_TX_MEM_WORDS_EN defined: the FIFO stores mem_addr and mem_data, and MADDR/MDATA words are emitted per REQ-029.
- REQ-040: Macro absent: the mem fields are not stored, MADDR/MDATA states are absent, and header bits [6:5] still report mem_rd and mem_wr.

Verification
- REQ-041: Scenario: pc=0x100, inst=0x00500093, rd_we=1, rd=1, data=5, tx_ready=1. Required stream: 0x00001080, 0x100, 0x00500093, 0x5; tx_last on the 4th word.
- REQ-042: Scenario: tx_ready=0, DEPTH=8, 10 events. Required: fifo_level=8, drop_count=2, and the 9th stored record has overflow=1 with seq=10.
- REQ-043: Scenario: flushed retire at pc=0x200. Required stream: header 0x4000 | seq<<16, then 0x200; tx_last on the 2nd word.
- REQ-044: Scenario: mem_wait=1 with ret_valid=1 for 3 cycles. Required: no capture and seq unchanged.
- REQ-045: Scenario: store to 0x80 with data 0xDEAD, with and without TRACE_TX_MEM_WORDS_EN. Required: 5 words ending 0x80, 0xDEAD when defined; 3 words when absent.
- REQ-046: Scenario: rst_n pulsed low while tx_valid=1 mid-record. Required: tx_valid=0 immediately and the next header has seq=0.
